// File: rtl/pooling_pkg.sv
// rtl/pooling_pkg.sv - shared types and constants for the pooling scheduler
package pooling_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int LEN_W_DEF  = 8;
  localparam int TOTAL_W    = 24;
  // Geometry span width: (255-1)*3 + 15 still fits, so no truncation.
  localparam int GEOM_W     = 11;

  // A zero stride or kernel can never describe a pooling window.
  localparam logic [1:0] STRIDE_ZERO = 2'd0;
  localparam logic [3:0] KERNEL_ZERO = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pooling_sched_out_agu.sv
// rtl/pooling_sched_out_agu.sv - output-buffer write address and result counter
module pool_out_agu
  import pooling_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [ADDR_W-1:0]  base,
  input  logic [TOTAL_W-1:0] total,
  input  logic               step,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               last
);

  logic [ADDR_W-1:0]  base_q;
  logic [TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0] cnt_q;

  // The strobe being stepped now is the final one of the layer.
  assign last = step && ((cnt_q + TOTAL_W'(1)) == total_q);

  // Load a new layer on accept; each step emits one write next cycle at base+count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en <= step;
      if (load) begin
        base_q  <= base;
        total_q <= total;
        cnt_q   <= '0;
      end else if (step) begin
        wr_addr <= base_q + cnt_q[ADDR_W-1:0];
        cnt_q   <= cnt_q + TOTAL_W'(1);
      end
    end
  end

endmodule

// File: rtl/pooling_sched.sv
// rtl/pooling_sched.sv - pooling layer pass sequencer for the IAGU
module pooling_sched
  import pooling_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [ADDR_W-1:0] i_addr_in_start,
  input  logic [ADDR_W-1:0] i_addr_out_start,
  input  logic [LEN_W-1:0]  i_in_x_length,
  input  logic [LEN_W-1:0]  i_out_x_length,
  input  logic [LEN_W-1:0]  i_out_y_length,
  input  logic [LEN_W-1:0]  i_in_piece,
  input  logic [3:0]        i_kernel,
  input  logic [1:0]        i_stride,
  output logic              o_iagu_start,
  output logic [ADDR_W-1:0] o_addr_start_d,
  output logic [LEN_W-1:0]  o_in_x_length,
  output logic [LEN_W-1:0]  o_out_x_length,
  output logic [LEN_W-1:0]  o_out_y_length,
  output logic [LEN_W-1:0]  o_in_piece,
  output logic [3:0]        o_kernel,
  output logic [1:0]        o_stride,
  input  logic              i_pooling_out,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int              WD_W     = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WD_W-1:0]    wd_q;
  logic               accept, strobe, timeout, cfg_legal, last;
  logic [GEOM_W-1:0]  span;
  logic [TOTAL_W-1:0] total;

  assign accept  = (state_q == ST_IDLE) && i_instr_valid;
  // A watchdog expiry wins over a strobe arriving in the same cycle.
  assign timeout = (state_q == ST_RUN) && (wd_q == WD_LIMIT);
  assign strobe  = (state_q == ST_RUN) && i_pooling_out && !timeout;
  assign total   = TOTAL_W'(i_out_x_length) * TOTAL_W'(i_out_y_length) * TOTAL_W'(i_in_piece);

  // Last window must end inside the input row.
  assign span = (GEOM_W'(o_out_x_length) - GEOM_W'(1)) * GEOM_W'(o_stride) + GEOM_W'(o_kernel);
  assign cfg_legal = (o_stride != STRIDE_ZERO) && (o_kernel != KERNEL_ZERO) &&
                     (o_out_x_length != '0) && (o_out_y_length != '0) &&
                     (o_in_piece != '0) && (span <= GEOM_W'(o_in_x_length));

  // Config registers feeding the IAGU, captured on accept and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_addr_start_d <= '0;
      o_in_x_length  <= '0;
      o_out_x_length <= '0;
      o_out_y_length <= '0;
      o_in_piece     <= '0;
      o_kernel       <= '0;
      o_stride       <= '0;
    end else if (accept) begin
      o_addr_start_d <= i_addr_in_start;
      o_in_x_length  <= i_in_x_length;
      o_out_x_length <= i_out_x_length;
      o_out_y_length <= i_out_y_length;
      o_in_piece     <= i_in_piece;
      o_kernel       <= i_kernel;
      o_stride       <= i_stride;
    end
  end

  // Watchdog: cleared outside RUN (so it enters RUN at zero) and on every result strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if ((state_q != ST_RUN) || i_pooling_out) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CHECK;
      ST_CHECK: state_d = cfg_legal ? ST_START : ST_IDLE;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (timeout)   state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_instr_ready = (state_q == ST_IDLE);
    o_busy        = (state_q != ST_IDLE);
    o_iagu_start  = (state_q == ST_START);
    o_done        = (state_q == ST_DONE);
    o_err         = ((state_q == ST_CHECK) && !cfg_legal) || timeout;
  end

  pool_out_agu #(
    .ADDR_W (ADDR_W)
  ) u_out_agu (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .base    (i_addr_out_start),
    .total   (total),
    .step    (strobe),
    .wr_en   (o_wr_en),
    .wr_addr (o_wr_addr),
    .last    (last)
  );

endmodule

// File: tb/tb_pooling_sched.sv
// tb/tb_pooling_sched.sv - randomized self-checking bench for pooling_sched
module tb_pooling_sched;

  localparam int ADDR_W  = 12;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_instr_valid = 1'b0;
  logic              o_instr_ready;
  logic [ADDR_W-1:0] i_addr_in_start = '0;
  logic [ADDR_W-1:0] i_addr_out_start = '0;
  logic [LEN_W-1:0]  i_in_x_length = '0;
  logic [LEN_W-1:0]  i_out_x_length = '0;
  logic [LEN_W-1:0]  i_out_y_length = '0;
  logic [LEN_W-1:0]  i_in_piece = '0;
  logic [3:0]        i_kernel = '0;
  logic [1:0]        i_stride = '0;
  logic              o_iagu_start;
  logic [ADDR_W-1:0] o_addr_start_d;
  logic [LEN_W-1:0]  o_in_x_length, o_out_x_length, o_out_y_length, o_in_piece;
  logic [3:0]        o_kernel;
  logic [1:0]        o_stride;
  logic              i_pooling_out = 1'b0;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic              o_busy, o_done, o_err;

  pooling_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
    .i_addr_in_start(i_addr_in_start), .i_addr_out_start(i_addr_out_start),
    .i_in_x_length(i_in_x_length), .i_out_x_length(i_out_x_length),
    .i_out_y_length(i_out_y_length), .i_in_piece(i_in_piece),
    .i_kernel(i_kernel), .i_stride(i_stride),
    .o_iagu_start(o_iagu_start), .o_addr_start_d(o_addr_start_d),
    .o_in_x_length(o_in_x_length), .o_out_x_length(o_out_x_length),
    .o_out_y_length(o_out_y_length), .o_in_piece(o_in_piece),
    .o_kernel(o_kernel), .o_stride(o_stride),
    .i_pooling_out(i_pooling_out), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit model_legal(int ix, int ox, int oy, int pc, int k, int s);
    return (s != 0) && (k != 0) && (ox != 0) && (oy != 0) && (pc != 0) &&
           ((ox - 1) * s + k <= ix);
  endfunction

  // Behavioural model: a job is tracked by its age since acceptance,
  // how many results it has produced and how long RUN has been silent.
  bit   job = 0, in_run = 0, finishing = 0, legal = 0;
  int   age = 0, silent = 0, total = 0, cnt = 0;
  logic [11:0] m_ain = '0, m_aout = '0;
  logic [7:0]  m_ix = '0, m_ox = '0, m_oy = '0, m_pc = '0;
  logic [3:0]  m_k = '0;
  logic [1:0]  m_s = '0;
  bit          e_wr;
  logic [11:0] e_addr;

  // Observation log for the directed scenarios.
  int cyc = 0;
  int n_acc = 0, acc_cyc = 0;
  int n_start = 0, start_cyc = 0;
  int n_done = 0, done_cyc = 0;
  int n_err = 0, err_cyc = 0;
  int last_wr_cyc = 0;
  int wr_log[$];

  initial begin : compare
    forever begin
      @(posedge clk);
      cyc++;
      e_wr = 0;
      e_addr = '0;
      if (rst) begin
        job = 0; in_run = 0; finishing = 0; age = 0; cnt = 0; silent = 0;
        m_ain = '0; m_aout = '0; m_ix = '0; m_ox = '0; m_oy = '0; m_pc = '0;
        m_k = '0; m_s = '0;
      end else if (!job) begin
        if (i_instr_valid) begin
          job = 1; age = 1; cnt = 0;
          m_ain = i_addr_in_start; m_aout = i_addr_out_start;
          m_ix = i_in_x_length; m_ox = i_out_x_length; m_oy = i_out_y_length;
          m_pc = i_in_piece; m_k = i_kernel; m_s = i_stride;
          legal = model_legal(m_ix, m_ox, m_oy, m_pc, m_k, m_s);
          total = int'(m_ox) * int'(m_oy) * int'(m_pc);
          n_acc++;
          acc_cyc = cyc;
        end
      end else if (finishing) begin
        job = 0; finishing = 0;
      end else if (age == 1) begin
        if (legal) age = 2;
        else job = 0;
      end else if (age == 2) begin
        age = 3; in_run = 1; silent = 0;
      end else begin
        if (silent == TIMEOUT - 1) begin
          job = 0; in_run = 0;
        end else if (i_pooling_out) begin
          e_wr = 1;
          e_addr = m_aout + 12'(cnt);
          cnt++;
          silent = 0;
          if (cnt == total) begin
            in_run = 0; finishing = 1;
          end
        end else begin
          silent++;
        end
      end
      #1;
      check("instr_ready", o_instr_ready, !job);
      check("busy", o_busy, job);
      check("iagu_start", o_iagu_start, job && age == 2);
      check("done", o_done, finishing);
      check("err", o_err, job && ((age == 1 && !legal) || (in_run && silent == TIMEOUT - 1)));
      check("wr_en", o_wr_en, e_wr);
      if (e_wr) check("wr_addr", o_wr_addr, e_addr);
      check("cfg_addr_start", o_addr_start_d, m_ain);
      check("cfg_in_x", o_in_x_length, m_ix);
      check("cfg_out_x", o_out_x_length, m_ox);
      check("cfg_out_y", o_out_y_length, m_oy);
      check("cfg_piece", o_in_piece, m_pc);
      check("cfg_kernel", o_kernel, m_k);
      check("cfg_stride", o_stride, m_s);
      if (o_wr_en) begin wr_log.push_back(int'(o_wr_addr)); last_wr_cyc = cyc; end
      if (o_iagu_start) begin n_start++; start_cyc = cyc; end
      if (o_done) begin n_done++; done_cyc = cyc; end
      if (o_err) begin n_err++; err_cyc = cyc; end
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    n_start = 0; n_done = 0; n_err = 0;
  endtask

  // Drive an instruction and return at the falling edge just after it is accepted.
  task automatic send(input logic [11:0] ain, input logic [11:0] aout,
                      input logic [7:0] ix, input logic [7:0] ox, input logic [7:0] oy,
                      input logic [7:0] pc, input logic [3:0] k, input logic [1:0] s,
                      input bit hold);
    int prev = n_acc;
    int guard = 0;
    i_addr_in_start = ain; i_addr_out_start = aout;
    i_in_x_length = ix; i_out_x_length = ox; i_out_y_length = oy;
    i_in_piece = pc; i_kernel = k; i_stride = s;
    i_instr_valid = 1'b1;
    while (n_acc == prev && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (n_acc == prev) check("send_accept_timeout", 0, 1);
    if (!hold) i_instr_valid = 1'b0;
  endtask

  task automatic wait_accept();
    int prev = n_acc;
    int guard = 0;
    while (n_acc == prev && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (n_acc == prev) check("wait_accept_timeout", 0, 1);
  endtask

  // Deliver n result strobes at random spacing, first one landing in RUN.
  task automatic pulses(input int n);
    int sent = 0;
    int guard = 0;
    if (n > 0) begin
      @(negedge clk);
      while (sent < n && guard < 2000) begin
        @(negedge clk);
        i_pooling_out = ($urandom_range(0, 2) != 0);
        if (i_pooling_out) sent++;
        guard++;
      end
      @(negedge clk);
      i_pooling_out = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int guard = 0;
    while (!o_instr_ready && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    if (!o_instr_ready) check("wait_idle_timeout", 0, 1);
  endtask

  initial begin : stimulus
    int exp_wrap[4];
    int nwr;
    exp_wrap = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    repeat (2) @(negedge clk);
    check("reset_ready", o_instr_ready, 1);
    check("reset_busy", o_busy, 0);
    check("reset_wr_en", o_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);

    check("model_total_plan", 4 * 2 * 2, 16);
    check("model_legal_plan", model_legal(12, 4, 2, 2, 3, 3), 1);
    check("model_legal_outx5", model_legal(12, 5, 2, 2, 3, 3), 0);

    // Legal pass from the plan.
    clear_logs();
    send(12'h040, 12'h100, 8'd12, 8'd4, 8'd2, 8'd2, 4'd3, 2'd3, 0);
    pulses(16);
    wait_idle(50);
    check("plan_start_after_accept", start_cyc - acc_cyc, 1);
    check("plan_start_count", n_start, 1);
    check("plan_wr_count", wr_log.size(), 16);
    for (int i = 0; i < wr_log.size() && i < 16; i++) check("plan_wr_seq", wr_log[i], 12'h100 + i);
    check("plan_done_count", n_done, 1);
    check("plan_done_with_last_wr", done_cyc, last_wr_cyc);
    check("plan_err_count", n_err, 0);

    // Illegal: stride zero.
    clear_logs();
    send(12'h000, 12'h100, 8'd12, 8'd4, 8'd2, 8'd2, 4'd3, 2'd0, 0);
    wait_idle(20);
    repeat (3) @(negedge clk);
    check("stride0_err_count", n_err, 1);
    check("stride0_err_in_check", err_cyc, acc_cyc);
    check("stride0_no_start", n_start, 0);

    // Illegal geometry: 4*3+3 = 15 > 12.
    clear_logs();
    send(12'h000, 12'h100, 8'd12, 8'd5, 8'd2, 8'd2, 4'd3, 2'd3, 0);
    wait_idle(20);
    repeat (3) @(negedge clk);
    check("outx5_err_count", n_err, 1);
    check("outx5_no_start", n_start, 0);

    // Output address wrap.
    clear_logs();
    send(12'h000, 12'hFFE, 8'd8, 8'd2, 8'd1, 8'd2, 4'd2, 2'd2, 0);
    pulses(4);
    wait_idle(50);
    check("wrap_wr_count", wr_log.size(), 4);
    for (int i = 0; i < wr_log.size() && i < 4; i++) check("wrap_wr_seq", wr_log[i], exp_wrap[i]);
    check("wrap_done_count", n_done, 1);

    // Valid held across a whole pass: the next instruction waits for IDLE.
    clear_logs();
    send(12'h000, 12'h100, 8'd12, 8'd4, 8'd2, 8'd2, 4'd3, 2'd3, 1);
    i_addr_out_start = 12'h280; i_in_x_length = 8'd8; i_out_x_length = 8'd2;
    i_out_y_length = 8'd1; i_in_piece = 8'd2; i_kernel = 4'd2; i_stride = 2'd2;
    pulses(16);
    wait_accept();
    i_instr_valid = 1'b0;
    check("hs_accept_after_done", acc_cyc - done_cyc, 2);
    pulses(4);
    wait_idle(50);
    check("hs_wr_count", wr_log.size(), 20);
    if (wr_log.size() == 20) check("hs_second_base", wr_log[16], 12'h280);
    check("hs_done_count", n_done, 2);
    nwr = wr_log.size();
    repeat (3) begin @(negedge clk); i_pooling_out = 1'b1; end
    @(negedge clk); i_pooling_out = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_strobe_no_write", wr_log.size(), nwr);

    // Watchdog timeout.
    clear_logs();
    send(12'h000, 12'h100, 8'd12, 8'd4, 8'd2, 8'd2, 4'd3, 2'd3, 0);
    pulses(3);
    wait_idle(TIMEOUT + 100);
    check("to_err_count", n_err, 1);
    check("to_err_distance", err_cyc - (last_wr_cyc - 1), TIMEOUT);
    check("to_no_done", n_done, 0);
    check("to_idle", o_instr_ready, 1);

    // Asynchronous reset in RUN after five strobes.
    clear_logs();
    send(12'h055, 12'h200, 8'd12, 8'd4, 8'd2, 8'd2, 4'd3, 2'd3, 0);
    pulses(5);
    #2 rst = 1'b1;
    #1;
    check("arst_wr_en", o_wr_en, 0);
    check("arst_wr_addr", o_wr_addr, 0);
    check("arst_ready", o_instr_ready, 1);
    check("arst_busy", o_busy, 0);
    check("arst_cfg_in_x", o_in_x_length, 0);
    check("arst_cfg_addr", o_addr_start_d, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    send(12'h000, 12'h300, 8'd8, 8'd2, 8'd1, 8'd2, 4'd2, 2'd2, 0);
    pulses(4);
    wait_idle(50);
    check("arst_restart_count", wr_log.size(), 4);
    if (wr_log.size() > 0) check("arst_restart_base", wr_log[0], 12'h300);

    // Randomized instructions, legal and illegal.
    for (int j = 0; j < 25; j++) begin
      logic [7:0] ix, ox, oy, pc;
      logic [3:0] k;
      logic [1:0] s;
      ix = 8'($urandom_range(0, 20)); ox = 8'($urandom_range(0, 5));
      oy = 8'($urandom_range(0, 3));  pc = 8'($urandom_range(0, 3));
      k  = 4'($urandom_range(0, 5));  s  = 2'($urandom_range(0, 3));
      send(12'($urandom), 12'($urandom), ix, ox, oy, pc, k, s, 0);
      if (model_legal(ix, ox, oy, pc, k, s)) pulses(int'(ox) * int'(oy) * int'(pc));
      wait_idle(50);
      @(negedge clk); i_pooling_out = 1'($urandom_range(0, 1));
      @(negedge clk); i_pooling_out = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pooling_sched.md
Name: pooling_sched

Overview:
- Sequences one pooling layer pass on the pooling input address generator (IAGU).
- Accepts a decoded pooling instruction over a valid/ready handshake, checks its geometry, holds the config registers that drive the IAGU, and pulses the IAGU start.
- Counts the IAGU result strobes and generates the output-buffer write-back address.
- Reports done or error to the schedule unit. Sits between decoder/schedule and the IAGU/output buffer.

Parameters:
- ADDR_W, 12, buffer address width.
- LEN_W, 8, length/piece field width.
- TIMEOUT, 4096, max cycles in RUN between IAGU result strobes before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- i_instr_valid  in  1  decoder holds a pooling instruction.
- o_instr_ready  out  1  high only in IDLE.
- i_addr_in_start  in  ADDR_W  input feature base address.
- i_addr_out_start  in  ADDR_W  output feature base address.
- i_in_x_length  in  LEN_W  input row length.
- i_out_x_length  in  LEN_W  output row length.
- i_out_y_length  in  LEN_W  output rows.
- i_in_piece  in  LEN_W  channel pieces; for pooling, in_piece equals out_piece.
- i_kernel  in  4  kernel size.
- i_stride  in  2  stride.
- o_iagu_start  out  1  one-cycle start to the IAGU.
- o_addr_start_d, o_in_x_length, o_out_x_length, o_out_y_length, o_in_piece, o_kernel, o_stride  out  (matching widths)  latched config to the IAGU.
- i_pooling_out  in  1  IAGU: one pooled result complete.
- o_wr_en  out  1  output-buffer write strobe.
- o_wr_addr  out  ADDR_W  output-buffer write address.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle pulse at layer completion.
- o_err  out  1  one-cycle pulse: illegal config or timeout.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values:
  - All outputs 0, except o_instr_ready = 1.
  - State IDLE; config registers 0; counters 0.
- FSM states: IDLE, CHECK, START, RUN, DONE.
- IDLE:
  - o_instr_ready = 1.
  - When valid and ready are both high at edge T, latch all config and the total result count into registers.
  - Next state CHECK.
- CHECK (1 cycle), legal only if all of the following hold:
  - stride != 0
  - kernel != 0
  - out_x, out_y and in_piece all != 0
  - (out_x - 1) * stride + kernel <= in_x, evaluated at 11 bits with no truncation.
  - Illegal: o_err pulses during this cycle; next state IDLE.
  - Legal: next state START.
- START: o_iagu_start = 1 for exactly this cycle, which is cycle T+2 after acceptance. Next state RUN.
- Total result count: out_x * out_y * in_piece, stored in a 24-bit register.
- RUN:
  - Each i_pooling_out produces one write: o_wr_en = 1 on the following cycle, with o_wr_addr = out_start + cnt, taken modulo 2^ADDR_W (wraps).
  - cnt increments on each strobe.
  - The strobe that brings cnt to total moves the FSM to DONE. Its write is still emitted on the next cycle.
- DONE: o_done = 1 for one cycle, coincident with the final o_wr_en. Next state IDLE.
- Timeout:
  - The watchdog counter resets on entry to RUN and on every i_pooling_out.
  - If it reaches TIMEOUT-1 in RUN: o_err pulses, FSM goes to IDLE, no o_done.
- i_pooling_out outside RUN is ignored: no write, no count.
- Config outputs are held stable from CHECK until the next accept.
- i_instr_valid while busy is not accepted, because ready is low.
- rst mid-operation: immediate return to reset values. Any pending write is dropped.

Decomposition:
- Shared package pooling_pkg holds:
  - state enum
  - ADDR_W / LEN_W defaults
  - TOTAL_W = 24
  - stride/kernel legality constants.
- One sub-module pool_out_agu: the output write-address/count generator (load base and total, step on strobe, flag last).

Test Plan:
- Legal pass: in_x=12, out_x=4, out_y=2, in_piece=2, kernel=3, stride=3, out_start=0x100; 16 strobes -> o_iagu_start at accept+2; writes 0x100..0x10F; o_done with the 16th write; no o_err.
- Illegal configs:
  - stride=0 -> o_err in CHECK, no o_iagu_start, back to IDLE.
  - out_x=5 with the config above (geometry 15 > 12) -> o_err.
- Address wrap: out_start=0xFFE, out_x=2, out_y=1, in_piece=2, in_x=8, kernel=2, stride=2 -> writes 0xFFE, 0xFFF, 0x000, 0x001, then o_done.
- Handshake: valid held through a whole pass -> ready=0 while busy; second instruction accepted only on the cycle after o_done; stray i_pooling_out in IDLE -> no o_wr_en.
- Timeout: legal config, 3 strobes then silence -> o_err exactly TIMEOUT cycles after the last strobe; FSM back in IDLE; no o_done.
- Async reset in RUN after 5 strobes -> outputs at reset values immediately; a fresh instruction afterwards restarts its writes at out_start.
